ahb_output_arbiter_dma: RTL and testbench

Round-robin arbiter for one output (slave-side) stage of the DMA bus matrix. It decides which input port owns the slave's address phase. It holds ownership across locked sequences and bursts, and tracks the data-phase owner. Its grant drives the output stage's address/control mux and data mux, and feeds back as the per-port `active` indication consumed by each input port's decoder stage.

---
 rtl/ahb_bm_pkg.sv | 36 +++
 rtl/ahb_rr_pick.sv | 31 +++
 rtl/ahb_output_arbiter_dma.sv | 131 +++++++++++++
 tb/tb_ahb_output_arbiter_dma.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HBURST encodings and burst-length helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_bm_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

  // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] burst);
    logic [3:0] len;
    case (burst)
      HB_WRAP4,  HB_INCR4:  len = 4'd3;
      HB_WRAP8,  HB_INCR8:  len = 4'd7;
      HB_WRAP16, HB_INCR16: len = 4'd15;
      default:              len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when to use the pick.
module ahb_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     winner,
  output logic                 any
);

  // Scan last+1 .. last+NUM_PORTS; the owner itself is checked last so it only wins when alone.
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    any    = |req;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_output_arbiter_dma.sv
// Output-stage arbiter: round-robin address-phase ownership held across locks/bursts.
// Latency: grant visible one HCLK after the request edge; data owner lags one more HREADYM edge.
// Backpressure: all state frozen while HREADYM is low.
module ahb_output_arbiter_dma
  import ahb_bm_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           trans_cur,
  input  logic [2:0]           burst_cur,
  input  logic                 lock_cur,
  input  logic                 HREADYM,
  output logic [IDX_W-1:0]     addr_in_port,
  output logic                 no_port,
  output logic [NUM_PORTS-1:0] active,
  output logic [IDX_W-1:0]     data_in_port,
  output logic                 data_active
);

  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             no_port_q, no_port_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic             incr_flag_q, incr_flag_d;
  logic [IDX_W-1:0] data_in_port_q;
  logic             data_active_q;

  logic             accepted;
  logic             rel;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_any;

  ahb_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .winner(pick_winner),
    .any   (pick_any)
  );

  // Hold/release decision in priority order, then round-robin re-arbitration on release.
  always_comb begin
    grant_d     = grant_q;
    last_d      = last_q;
    no_port_d   = no_port_q;
    beat_cnt_d  = beat_cnt_q;
    incr_flag_d = incr_flag_q;
    rel         = 1'b0;
    accepted    = !no_port_q && req[grant_q] && trans_cur[1];

    if (!no_port_q && lock_cur && req[grant_q]) begin
      rel = 1'b0;
    end else if (accepted && trans_cur == HT_NONSEQ) begin
      if (burst_cur == HB_SINGLE) begin
        rel = 1'b1;
      end else if (burst_cur == HB_INCR) begin
        incr_flag_d = 1'b1;
        beat_cnt_d  = 4'd0;
      end else begin
        // A fresh fixed burst supersedes any previous undefined-length burst.
        incr_flag_d = 1'b0;
        beat_cnt_d  = burst_len_m1(burst_cur);
      end
    end else if (accepted && trans_cur == HT_SEQ) begin
      if (incr_flag_q) begin
        rel = 1'b0;
      end else if (beat_cnt_q > 4'd1) begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end else begin
        // Last beat, or a stray SEQ with no burst in flight.
        rel = 1'b1;
      end
    end else if (!no_port_q && trans_cur == HT_BUSY && req[grant_q]
                 && (beat_cnt_q != 4'd0 || incr_flag_q)) begin
      rel = 1'b0;
    end else begin
      rel = 1'b1;
    end

    if (rel) begin
      beat_cnt_d  = 4'd0;
      incr_flag_d = 1'b0;
      if (pick_any) begin
        grant_d   = pick_winner;
        last_d    = pick_winner;
        no_port_d = 1'b0;
      end else begin
        no_port_d = 1'b1;
      end
    end
  end

  // State register; only HREADYM-qualified edges advance address and data phases.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q        <= '0;
      last_q         <= IDX_W'(NUM_PORTS - 1);
      no_port_q      <= 1'b1;
      beat_cnt_q     <= 4'd0;
      incr_flag_q    <= 1'b0;
      data_in_port_q <= '0;
      data_active_q  <= 1'b0;
    end else if (HREADYM) begin
      grant_q        <= grant_d;
      last_q         <= last_d;
      no_port_q      <= no_port_d;
      beat_cnt_q     <= beat_cnt_d;
      incr_flag_q    <= incr_flag_d;
      data_in_port_q <= grant_q;
      data_active_q  <= accepted;
    end
  end

  // One-hot owner indication back to the input-port decoders.
  always_comb begin
    active = '0;
    if (!no_port_q) active[grant_q] = 1'b1;
  end

  assign addr_in_port = grant_q;
  assign no_port      = no_port_q;
  assign data_in_port = data_in_port_q;
  assign data_active  = data_active_q;

endmodule

// File: tb/tb_ahb_output_arbiter_dma.sv
// Directed bench for the output-stage arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next edge.
// Backpressure: HREADYM stalls exercised directly.
module tb_ahb_output_arbiter_dma;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
                         INCR8 = 3'd5, INCR16 = 3'd7;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [2:0] req;
  logic [1:0] trans_cur;
  logic [2:0] burst_cur;
  logic       lock_cur;
  logic       HREADYM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [2:0] active;
  logic [1:0] data_in_port;
  logic       data_active;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_output_arbiter_dma #(.NUM_PORTS(3), .IDX_W(2)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .req         (req),
    .trans_cur   (trans_cur),
    .burst_cur   (burst_cur),
    .lock_cur    (lock_cur),
    .HREADYM     (HREADYM),
    .addr_in_port(addr_in_port),
    .no_port     (no_port),
    .active      (active),
    .data_in_port(data_in_port),
    .data_active (data_active)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [1:0] t, input logic [2:0] b);
    req       = r;
    trans_cur = t;
    burst_cur = b;
  endtask

  task automatic chk_owner(input string tag, input logic [1:0] port);
    chk({tag, "_addr"}, 32'(addr_in_port), 32'(port));
    chk({tag, "_nop"}, 32'(no_port), 32'd0);
  endtask

  initial begin
    HRESET = 1'b1; HREADYM = 1'b1; lock_cur = 1'b0;
    drive(3'b000, IDLE, SINGLE);
    tick(); tick();
    chk("rst_addr", 32'(addr_in_port), 32'd0);
    chk("rst_nop", 32'(no_port), 32'd1);
    chk("rst_act", 32'(active), 32'd0);
    chk("rst_dport", 32'(data_in_port), 32'd0);
    chk("rst_dact", 32'(data_active), 32'd0);

    // Round robin over three SINGLE requesters.
    HRESET = 1'b0;
    drive(3'b111, NSEQ, SINGLE);
    tick();
    chk_owner("rr0", 2'd0);
    chk("rr0_act", 32'(active), 32'b001);
    chk("rr0_dact", 32'(data_active), 32'd0);
    tick();
    chk_owner("rr1", 2'd1);
    chk("rr1_dport", 32'(data_in_port), 32'd0);
    chk("rr1_dact", 32'(data_active), 32'd1);
    tick();
    chk_owner("rr2", 2'd2);
    chk("rr2_act", 32'(active), 32'b100);
    chk("rr2_dport", 32'(data_in_port), 32'd1);

    // Hand ownership to port 1, then INCR4 with everyone requesting.
    drive(3'b010, IDLE, SINGLE);
    tick();
    chk_owner("i4_pre", 2'd1);
    drive(3'b111, NSEQ, INCR4);
    tick();
    chk_owner("i4_b1", 2'd1);
    chk("i4_b1_cnt", 32'(dut.beat_cnt_q), 32'd3);
    drive(3'b111, SEQ, INCR4);
    tick(); chk_owner("i4_b2", 2'd1);
    tick(); chk_owner("i4_b3", 2'd1);
    chk("i4_b3_cnt", 32'(dut.beat_cnt_q), 32'd1);
    tick();
    chk_owner("i4_b4", 2'd2);
    chk("i4_b4_cnt", 32'(dut.beat_cnt_q), 32'd0);

    // INCR8 on port 2: stall at beat 5, BUSY before beat 6.
    drive(3'b101, NSEQ, INCR8);
    tick();
    drive(3'b101, SEQ, INCR8);
    tick(); tick(); tick();
    chk_owner("i8_b4", 2'd2);
    chk("i8_b4_cnt", 32'(dut.beat_cnt_q), 32'd4);
    HREADYM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_owner("i8_stall", 2'd2);
      chk("i8_stall_cnt", 32'(dut.beat_cnt_q), 32'd4);
      chk("i8_stall_dact", 32'(data_active), 32'd1);
    end
    HREADYM = 1'b1;
    tick();
    chk("i8_b5_cnt", 32'(dut.beat_cnt_q), 32'd3);
    drive(3'b101, BUSY, INCR8);
    tick();
    chk_owner("i8_busy", 2'd2);
    chk("i8_busy_cnt", 32'(dut.beat_cnt_q), 32'd3);
    chk("i8_busy_dact", 32'(data_active), 32'd0);
    drive(3'b101, SEQ, INCR8);
    tick(); tick();
    chk_owner("i8_b7", 2'd2);
    tick();
    chk_owner("i8_b8", 2'd0);
    chk("i8_end_cnt", 32'(dut.beat_cnt_q), 32'd0);

    // Port 0 locked over two SINGLEs while port 2 waits.
    lock_cur = 1'b1;
    drive(3'b101, NSEQ, SINGLE);
    tick(); chk_owner("lk1", 2'd0);
    tick(); chk_owner("lk2", 2'd0);
    chk("lk2_dact", 32'(data_active), 32'd1);
    lock_cur = 1'b0;
    drive(3'b100, IDLE, SINGLE);
    tick();
    chk_owner("lk_rel", 2'd2);
    chk("lk_rel_act", 32'(active), 32'b100);

    // WRAP4 cut short by IDLE after two beats.
    drive(3'b101, NSEQ, WRAP4);
    tick();
    drive(3'b101, SEQ, WRAP4);
    tick();
    chk_owner("w4_b2", 2'd2);
    chk("w4_b2_cnt", 32'(dut.beat_cnt_q), 32'd2);
    drive(3'b101, IDLE, WRAP4);
    tick();
    chk_owner("w4_idle", 2'd0);
    chk("w4_idle_dact", 32'(data_active), 32'd0);
    chk("w4_idle_cnt", 32'(dut.beat_cnt_q), 32'd0);
    chk("w4_idle_incr", 32'(dut.incr_flag_q), 32'd0);

    // Undefined-length INCR on port 0 ended by IDLE.
    drive(3'b101, NSEQ, INCR);
    tick();
    chk("incr_flag_set", 32'(dut.incr_flag_q), 32'd1);
    drive(3'b101, SEQ, INCR);
    tick(); tick();
    chk_owner("incr_hold", 2'd0);
    drive(3'b101, IDLE, INCR);
    tick();
    chk_owner("incr_rel", 2'd2);
    chk("incr_flag_clr", 32'(dut.incr_flag_q), 32'd0);

    // Reset in the middle of an INCR16 on port 2.
    drive(3'b111, NSEQ, INCR16);
    tick();
    drive(3'b111, SEQ, INCR16);
    for (int i = 0; i < 6; i++) tick();
    chk_owner("i16_b7", 2'd2);
    chk("i16_b7_cnt", 32'(dut.beat_cnt_q), 32'd9);
    HRESET = 1'b1;
    tick();
    chk("i16_rst_nop", 32'(no_port), 32'd1);
    chk("i16_rst_act", 32'(active), 32'd0);
    chk("i16_rst_dact", 32'(data_active), 32'd0);
    chk("i16_rst_cnt", 32'(dut.beat_cnt_q), 32'd0);
    HRESET = 1'b0;
    drive(3'b110, NSEQ, SINGLE);
    tick();
    chk_owner("post_rst", 2'd1);
    chk("post_rst_act", 32'(active), 32'b010);

    // No requesters: owner index holds, no_port rises.
    drive(3'b000, IDLE, SINGLE);
    tick();
    chk("none_nop", 32'(no_port), 32'd1);
    chk("none_addr", 32'(addr_in_port), 32'd1);
    chk("none_act", 32'(active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
